// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and constants for the single-port VRAM arbiter.
package vram_arb_pkg;
  localparam int AW_DEF = 11;
  localparam int DW_DEF = 8;
  localparam logic [10:0] SCREEN_BASE = 11'h000;
  localparam logic [10:0] CHAR_BASE = 11'h400;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
  typedef enum logic [1:0] {CPU_IDLE, CPU_PEND, CPU_FLIGHT, CPU_DONE} cpu_state_t;
endpackage

// File: rtl/vram_arb_track.sv
// vram_arb_track: two-stage slot owner pipeline routing synchronous RAM returns.
module vram_arb_track
  import vram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  owner_t slot,
  input  logic   slot_we,
  output logic   vid_valid,
  output logic   cpu_done,
  output logic   cpu_load
);
  owner_t s1, s2;
  logic we1, we2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= OWN_NONE;
      s2 <= OWN_NONE;
      we1 <= 1'b0;
      we2 <= 1'b0;
    end else begin
      s1 <= slot;
      s2 <= s1;
      we1 <= slot_we;
      we2 <= we1;
    end
  assign vid_valid = s2 == OWN_VID;
  assign cpu_done = s2 == OWN_CPU;
  assign cpu_load = cpu_done & ~we2;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between video fetch (priority) and Z80.
// Define VRAM_ARB_CONTENTION_EN to hold the CPU off for the whole active display.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  input  logic          vid_active,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);
  cpu_state_t state, nxt;
  owner_t slot;
  logic elig, pend, cpu_done, cpu_load;
  logic [DW-1:0] cpu_q, vid_q;
`ifdef VRAM_ARB_CONTENTION_EN
  assign elig = ~vid_active;
`else
  logic unused_vid_active;
  assign unused_vid_active = vid_active;
  assign elig = 1'b1;
`endif
  assign pend = cpu_req & (state == CPU_IDLE | state == CPU_PEND);
  assign slot = vid_req ? OWN_VID : (pend & elig) ? OWN_CPU : OWN_NONE;
  // The done pulse counts as DONE so the CPU is released the cycle data returns.
  assign cpu_wait_n = ~(cpu_req & state != CPU_DONE & ~cpu_done);
  assign vid_rdata = vid_valid ? ram_rdata : vid_q;
  assign cpu_rdata = cpu_load ? ram_rdata : cpu_q;
  vram_arb_track u_track (
    .clk(clk),
    .reset_n(reset_n),
    .slot(slot),
    .slot_we(slot == OWN_CPU & cpu_we),
    .vid_valid(vid_valid),
    .cpu_done(cpu_done),
    .cpu_load(cpu_load)
  );
  always_comb begin
    nxt = state;
    case (state)
      CPU_IDLE, CPU_PEND: nxt = !cpu_req ? CPU_IDLE : slot == OWN_CPU ? CPU_FLIGHT : CPU_PEND;
      CPU_FLIGHT: nxt = !cpu_done ? CPU_FLIGHT : cpu_req ? CPU_DONE : CPU_IDLE;
      default: nxt = cpu_req ? CPU_DONE : CPU_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= CPU_IDLE;
      ram_addr <= '0;
      ram_wdata <= '0;
      ram_we <= 1'b0;
      cpu_q <= '0;
      vid_q <= '0;
    end else begin
      state <= nxt;
      ram_we <= slot == OWN_CPU & cpu_we;
      ram_addr <= slot == OWN_VID ? vid_addr : slot == OWN_CPU ? cpu_addr : ram_addr;
      ram_wdata <= slot == OWN_CPU ? cpu_wdata : ram_wdata;
      if (vid_valid) vid_q <= ram_rdata;
      if (cpu_load) cpu_q <= ram_rdata;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a
// transaction-level model of slot priority, latency and RAM contents.
module tb_vram_arbiter;
  logic clk = 0, reset_n = 1;
  logic cpu_req = 0, cpu_we = 0, vid_req = 0, vid_active = 0;
  logic [10:0] cpu_addr = '0, vid_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata, vid_rdata, ram_wdata, ram_rdata;
  logic cpu_wait_n, vid_valid, ram_we;
  logic [10:0] ram_addr;

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_wait_n(cpu_wait_n), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_active(vid_active), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [2048];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {int due; logic [7:0] d;} vret_t;
  vret_t vq[$];
  logic [7:0] ref_mem [2048];
  int checks = 0, errors = 0, cyc = 0, done_cyc = 0, we_pulses = 0;
  logic served = 0, m_we = 0, n_we = 0, e_we = 0, e_valid = 0, e_wait = 1;
  logic [7:0] m_rd = '0, e_crd = '0, last_vd = '0, n_wd = '0, e_wd = '0;
  logic [10:0] n_addr = '0, e_addr = '0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic done_now();
    return served && cyc >= done_cyc;
  endfunction

  task automatic model_reset();
    vq.delete();
    served = 0; n_we = 0; n_addr = '0; n_wd = '0; e_crd = '0; last_vd = '0;
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, check at negedge.
  task automatic step(input logic vr, input logic [10:0] va, input logic vact,
                      input logic cr, input logic cwe, input logic [10:0] ca, input logic [7:0] cwd);
    logic elig;
    @(posedge clk); #1;
    vid_req = vr; vid_addr = va; vid_active = vact;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    cyc++;
    e_addr = n_addr; e_wd = n_wd; e_we = n_we; n_we = 0; e_valid = 0;
    if (vq.size() > 0 && vq[0].due == cyc) begin
      e_valid = 1; last_vd = vq[0].d; void'(vq.pop_front());
    end
    if (!cr) served = 0;
    if (served && cyc == done_cyc && !m_we) e_crd = m_rd;
    e_wait = !(cr && !done_now());
`ifdef VRAM_ARB_CONTENTION_EN
    elig = !vact;
`else
    elig = 1;
`endif
    if (vr) begin
      vq.push_back(vret_t'{cyc + 2, ref_mem[va]});
      n_addr = va;
    end else if (cr && !served && elig) begin
      served = 1; done_cyc = cyc + 2; m_we = cwe;
      n_addr = ca; n_wd = cwd; n_we = cwe;
      if (cwe) ref_mem[ca] = cwd; else m_rd = ref_mem[ca];
    end
    @(negedge clk);
    chk("cpu_wait_n", 16'(cpu_wait_n), 16'(e_wait));
    chk("ram_we", 16'(ram_we), 16'(e_we));
    chk("ram_addr", 16'(ram_addr), 16'(e_addr));
    chk("ram_wdata", 16'(ram_wdata), 16'(e_wd));
    chk("vid_valid", 16'(vid_valid), 16'(e_valid));
    chk("vid_rdata", 16'(vid_rdata), 16'(last_vd));
    chk("cpu_rdata", 16'(cpu_rdata), 16'(e_crd));
    if (ram_we) we_pulses++;
  endtask

  // Full CPU access; vmode 0 none, 1 first 5 cycles, 2 alternating, 3 random video.
  task automatic txn(input logic we, input logic [10:0] a, input logic [7:0] d,
                     input int vmode, input int vact_cycles, input int hold, output int waits);
    int n = 0;
    logic vr;
    waits = 0;
    while (n < 300) begin
      vr = vmode == 1 ? n < 5 : vmode == 2 ? n % 2 == 0 : vmode == 3 ? 1'($urandom_range(0, 1)) : 1'b0;
      step(vr, 11'($urandom_range(0, 2047)), n < vact_cycles, 1, we, a, d);
      if (!cpu_wait_n) waits++;
      n++;
      if (done_now()) break;
    end
    chk("txn_bound", 16'(n < 300), 16'd1);
    for (int i = 0; i < hold; i++)
      step(vmode == 3 ? 1'($urandom_range(0, 1)) : 1'b0, 11'($urandom_range(0, 2047)), 0, 1, we, a, d);
    step(vmode == 3 ? 1'($urandom_range(0, 1)) : 1'b0, 11'($urandom_range(0, 2047)), 0, 0, we, a, d);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 2048; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[i] = ref_mem[i];
    end
    ref_mem[11'h123] = 8'h5A;
    mem[11'h123] = 8'h5A;
    #2 reset_n = 0;
    #2;
    chk("rst_ram_we", 16'(ram_we), 16'd0);
    chk("rst_ram_addr", 16'(ram_addr), 16'd0);
    chk("rst_ram_wdata", 16'(ram_wdata), 16'd0);
    chk("rst_cpu_rdata", 16'(cpu_rdata), 16'd0);
    chk("rst_vid_rdata", 16'(vid_rdata), 16'd0);
    chk("rst_vid_valid", 16'(vid_valid), 16'd0);
    chk("rst_wait_n", 16'(cpu_wait_n), 16'd1);
    @(negedge clk); @(negedge clk);
    reset_n = 1;

    txn(0, 11'h123, 8'h00, 0, 0, 1, w);
    chk("iso_read_waits", 16'(w), 16'd2);
    chk("iso_read_data", 16'(cpu_rdata), 16'h5A);

    we_pulses = 0;
    txn(1, 11'h400, 8'h3C, 0, 0, 4, w);
    chk("write_we_pulses", 16'(we_pulses), 16'd1);
    txn(0, 11'h400, 8'h00, 0, 0, 0, w);
    chk("readback_data", 16'(cpu_rdata), 16'h3C);

    txn(0, 11'h123, 8'h00, 1, 0, 0, w);
    chk("vid_burst_waits", 16'(w), 16'd7);

    for (int i = 0; i < 4; i++) begin
      txn(0, 11'($urandom_range(0, 2047)), 8'h00, 2, 0, 0, w);
      chk("alt_waits", 16'(w), 16'd3);
    end

    txn(0, 11'h7FF, 8'h00, 0, 20, 0, w);
`ifdef VRAM_ARB_CONTENTION_EN
    chk("active_waits", 16'(w), 16'd22);
`else
    chk("active_waits", 16'(w), 16'd2);
`endif

    for (int i = 0; i < 30; i++) begin
      txn(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 8'($urandom), 3, 0,
          $urandom_range(0, 2), w);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        step(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 0, 0, 0, '0, '0);
    end

    step(0, '0, 0, 1, 1, 11'h2AA, 8'h99);
    @(posedge clk); #1;
    cyc++;
    chk("pre_rst_we", 16'(ram_we), 16'd1);
    reset_n = 0;
    #1;
    chk("mid_rst_we", 16'(ram_we), 16'd0);
    chk("mid_rst_valid", 16'(vid_valid), 16'd0);
    chk("mid_rst_wait_n", 16'(cpu_wait_n), 16'd0);
    chk("mid_rst_addr", 16'(ram_addr), 16'd0);
    cpu_req = 0;
    #1;
    chk("mid_rst_idle_wait_n", 16'(cpu_wait_n), 16'd1);
    @(negedge clk);
    reset_n = 1;
    model_reset();
    ref_mem[11'h2AA] = mem[11'h2AA];
    txn(0, 11'h2AA, 8'h00, 0, 0, 0, w);
    chk("post_rst_waits", 16'(w), 16'd2);
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 0, 0, 0, '0, '0);
    step(0, '0, 0, 0, 0, '0, '0);
    step(0, '0, 0, 0, 0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
